// File: rtl/control_unit.sv
// Multi-cycle RV32I subset control FSM (lw, sw, R-type add/sub/and/or, addi, beq).
// Build option: define CONTROL_UNIT_TRAP_EN so that unsupported instructions latch into TRAP instead of running as a NOP.
module control_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       PCSource,
  output logic       RegWrite,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUCtrl,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_EXECI  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_BRNT   = 4'd10;
`ifdef CONTROL_UNIT_TRAP_EN
  localparam logic [3:0] S_TRAP   = 4'd11;
  localparam logic [3:0] S_UNSUP  = S_TRAP;
`else
  localparam logic [3:0] S_UNSUP  = S_BRNT;
`endif

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       is_store_q;
  logic [3:0] alu_sel_q;

  logic [3:0] dec_next;
  logic [3:0] dec_alu;

  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;
  logic       ir_write_raw;
  logic       retire_raw;

  // Dispatch decision: only meaningful while in DECODE.
  always_comb begin
    dec_next = S_UNSUP;
    dec_alu  = ALU_ADD;
    case (opcode)
      OP_LOAD,
      OP_STORE:  dec_next = S_MEMADR;
      OP_RTYPE: begin
        case (funct3)
          3'b000: begin
            dec_next = S_EXEC;
            dec_alu  = funct7_5 ? ALU_SUB : ALU_ADD;
          end
          3'b111: begin
            dec_next = S_EXEC;
            dec_alu  = ALU_AND;
          end
          3'b110: begin
            dec_next = S_EXEC;
            dec_alu  = ALU_OR;
          end
          default: dec_next = S_UNSUP;
        endcase
      end
      OP_ITYPE:  dec_next = (funct3 == 3'b000) ? S_EXECI : S_UNSUP;
      OP_BRANCH: dec_next = (funct3 == 3'b000) ? S_BRANCH : S_UNSUP;
      default:   dec_next = S_UNSUP;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = dec_next;
      S_MEMADR: state_d = is_store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_EXECI:  state_d = S_ALUWB;
      S_BRANCH: state_d = zero ? S_FETCH : S_BRNT;
      S_BRNT:   state_d = S_FETCH;
`ifdef CONTROL_UNIT_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction fields are only trusted in DECODE, so the parts needed later are held here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_store_q <= 1'b0;
      alu_sel_q  <= ALU_ADD;
    end else if (state_q == S_DECODE) begin
      is_store_q <= (opcode == OP_STORE);
      alu_sel_q  <= dec_alu;
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    PCSource      = 1'b0;
    reg_write_raw = 1'b0;
    ALUSrcB       = 2'b00;
    ALUCtrl       = ALU_ADD;
    retire_raw    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead      = 1'b1;
        ir_write_raw = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead      = 1'b1;
        IorD         = 1'b1;
        ALUSrcB      = 2'b01;
        pc_write_raw = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
        ALUSrcB       = 2'b01;
        pc_write_raw  = 1'b1;
        retire_raw    = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtrl = alu_sel_q;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        ALUSrcB       = 2'b01;
        pc_write_raw  = 1'b1;
        retire_raw    = 1'b1;
      end
      S_EXECI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_BRANCH: begin
        // Taken branch writes the target held in ALUOut and completes here.
        ALUSrcA      = 1'b1;
        ALUCtrl      = ALU_SUB;
        PCSource     = 1'b1;
        pc_write_raw = zero;
        retire_raw   = zero;
      end
      S_BRNT: begin
        ALUSrcB      = 2'b01;
        pc_write_raw = 1'b1;
        retire_raw   = 1'b1;
      end
      default: begin
        ALUCtrl = 4'b0000;
      end
    endcase
  end

  // Write strobes are suppressed for the whole time reset is held.
  assign PCWrite  = pc_write_raw & reset_n;
  assign MemWrite = mem_write_raw & reset_n;
  assign RegWrite = reg_write_raw & reset_n;
  assign IRWrite  = ir_write_raw & reset_n;
  assign retire   = retire_raw & reset_n;
  assign state    = state_q;

`ifdef CONTROL_UNIT_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule
